split_nibble_tx: RTL and testbench
==================================

SPLIT_NIBBLE_TX -- requirements
Module: split_nibble_tx

Interface
REQ-001 Parameter DEPTH, default 4, input word FIFO depth in entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter CNT_W, default 8, width of the completed-word counter.
REQ-003 clk_ee  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n_ee  input  1  reset, asynchronous, active-low.
REQ-005 in_valid_ee  input  1  byte offered on in_data_ee.
REQ-006 in_ready_ee  output  1  FIFO can accept a byte this cycle.
REQ-007 in_data_ee  input  8  byte to transmit.
REQ-008 out_valid_ee  output  1  nibble present on out_nib_ee.
REQ-009 out_ready_ee  input  1  downstream accepts the nibble.
REQ-010 out_nib_ee  output  4  current nibble.
REQ-011 out_last_ee  output  1  marks the final beat of a word.
REQ-012 word_cnt_ee  output  CNT_W  count of fully transmitted words.
REQ-013 busy_ee  output  1  high when state is not IDLE or FIFO is not empty.

Function
REQ-014 Push SHALL occur when in_valid_ee && in_ready_ee; in_ready_ee SHALL equal !full, combinationally.
REQ-015 FSM states: IDLE, SEND_LO, SEND_HI (SEND_PAR only with the REQ-027 feature enabled).
REQ-016 IDLE: FIFO non-empty -> pop into hold register, go to SEND_LO; otherwise stay in IDLE.
REQ-017 SEND_LO: out_valid_ee=1, out_nib_ee=hold[3:0], out_last_ee=0; on out_ready_ee -> SEND_HI.
REQ-018 SEND_HI: out_valid_ee=1, out_nib_ee=hold[7:4], out_last_ee=1; on out_ready_ee: FIFO non-empty -> pop, SEND_LO (back-to-back); empty -> IDLE.
REQ-019 While out_valid_ee && !out_ready_ee, out_nib_ee and out_last_ee SHALL hold stable.
REQ-020 Latency: byte pushed into an empty FIFO in an idle block at edge N SHALL produce out_valid_ee=1 from edge N+2.
REQ-021 Sustained throughput with out_ready_ee=1 SHALL be one word per 2 cycles, with no bubble between words.
REQ-022 Simultaneous push and pop on a non-full FIFO SHALL leave occupancy unchanged; no push SHALL occur when full, even if a pop occurs in the same cycle.
REQ-023 FIFO pointers SHALL wrap modulo DEPTH; the full/empty distinction SHALL use an extra pointer bit.
REQ-024 word_cnt_ee SHALL increment by 1 on the out_last_ee handshake, wrapping from 2^CNT_W-1 to 0.

Reset
REQ-025 During reset: state=IDLE, FIFO empty, hold=0, out_valid_ee=0, out_nib_ee=0, out_last_ee=0, word_cnt_ee=0, busy_ee=0, in_ready_ee=1.
REQ-026 Reset asserted mid-word SHALL discard the in-flight word and all FIFO contents; word_cnt_ee SHALL NOT count the discarded word.

Configuration
REQ-027 Macro SPLIT_NIBBLE_TX_PARITY_EN defined: after SEND_HI handshake -> SEND_PAR, with out_nib_ee={3'b000, ^hold}, out_last_ee=1 on SEND_PAR only, 3 cycles per word; SEND_PAR exits as SEND_HI does in REQ-018.
REQ-028 Macro not defined: two beats per word exactly as REQ-017/018; the port list SHALL be identical in both builds.

Structure
REQ-029 Package split_tx_pkg SHALL hold the state enum typedef (2-bit), NIB_W=4, BYTE_W=8.
REQ-030 Sub-module split_tx_fifo (parameter DEPTH, 8-bit data, push/pop/full/empty) SHALL implement the FIFO; the FSM, counter and output logic SHALL live in split_nibble_tx.

Verification
REQ-031 Single byte 8'hA5, out_ready_ee=1 -> beats 4'h5 (last=0) then 4'hA (last=1); word_cnt_ee=1.
REQ-032 Bytes 8'h12, 8'h34 back-to-back, out_ready_ee=1 -> nibbles 2,1,4,3 on 4 consecutive cycles; word_cnt_ee=2.
REQ-033 out_ready_ee=0, push 5 bytes at DEPTH=4 -> in_ready_ee=0 once the FIFO is full; release out_ready_ee -> all accepted bytes emitted in order, none lost.
REQ-034 Hold out_ready_ee=0 for 3 cycles on 8'hC3 low beat -> out_nib_ee stays 4'h3 throughout.
REQ-035 CNT_W=2, send 5 words -> word_cnt_ee sequence 1,2,3,0,1.
REQ-036 Reset asserted during SEND_HI -> all outputs per REQ-025 immediately; first word after release starts at its low nibble; PARITY_EN build: 8'h07 -> beats 7,0,1 with last on 1.

Source files
------------

// File: rtl/split_tx_pkg.sv
// rtl/split_tx_pkg.sv - shared widths and FSM state type for the nibble transmitter.
// SPLIT_NIBBLE_TX_PARITY_EN adds the SEND_PAR state.
package split_tx_pkg;

   localparam int NIB_W  = 4;
   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND_LO  = 2'd1,
`ifdef SPLIT_NIBBLE_TX_PARITY_EN
      SEND_HI  = 2'd2,
      SEND_PAR = 2'd3
`else
      SEND_HI  = 2'd2
`endif
   } tx_state_e;

endpackage

// File: rtl/split_nibble_tx_if.sv
// rtl/split_nibble_tx_if.sv - byte-in / nibble-out handshake bundle.
// slave is the transmitter's view, master is the driver/sink side.
interface split_nibble_tx_if;
   import split_tx_pkg::*;

   logic              in_valid_ee;
   logic              in_ready_ee;
   logic [BYTE_W-1:0] in_data_ee;
   logic              out_valid_ee;
   logic              out_ready_ee;
   logic [NIB_W-1:0]  out_nib_ee;
   logic              out_last_ee;

   modport master (
      output in_valid_ee, in_data_ee, out_ready_ee,
      input  in_ready_ee, out_valid_ee, out_nib_ee, out_last_ee
   );

   modport slave (
      input  in_valid_ee, in_data_ee, out_ready_ee,
      output in_ready_ee, out_valid_ee, out_nib_ee, out_last_ee
   );

endinterface

// File: rtl/split_tx_fifo.sv
// rtl/split_tx_fifo.sv - byte FIFO, power-of-two depth, extra pointer bit separates full from empty.
module split_tx_fifo
   import split_tx_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk_ee,
   input  logic              rst_n_ee,
   input  logic              push,
   input  logic [BYTE_W-1:0] push_data,
   input  logic              pop,
   output logic [BYTE_W-1:0] pop_data,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic [BYTE_W-1:0] mem [DEPTH];
   logic              do_push;
   logic              do_pop;

   // A push against a full FIFO is dropped even if a pop frees a slot this cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_ee or negedge rst_n_ee) begin
      if (!rst_n_ee) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_ee) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/split_nibble_tx.sv
// rtl/split_nibble_tx.sv - sends each queued byte as low nibble then high nibble.
// SPLIT_NIBBLE_TX_PARITY_EN appends a third parity beat per word.
module split_nibble_tx
   import split_tx_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                clk_ee,
   input  logic                rst_n_ee,
   split_nibble_tx_if.slave    bus,
   output logic [CNT_W-1:0]    word_cnt_ee,
   output logic                busy_ee
);

   tx_state_e         state;
   tx_state_e         state_nxt;
   logic [BYTE_W-1:0] hold;
   logic [BYTE_W-1:0] fifo_dout;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;
   logic              word_done;

   split_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_ee    (clk_ee),
      .rst_n_ee  (rst_n_ee),
      .push      (bus.in_valid_ee),
      .push_data (bus.in_data_ee),
      .pop       (fifo_pop),
      .pop_data  (fifo_dout),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign bus.in_ready_ee = !fifo_full;
   assign busy_ee         = (state != IDLE) || !fifo_empty;

   always_comb begin
      state_nxt        = state;
      fifo_pop         = 1'b0;
      word_done        = 1'b0;
      bus.out_valid_ee = 1'b0;
      bus.out_nib_ee   = '0;
      bus.out_last_ee  = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               state_nxt = SEND_LO;
            end
         end
         SEND_LO: begin
            bus.out_valid_ee = 1'b1;
            bus.out_nib_ee   = hold[NIB_W-1:0];
            if (bus.out_ready_ee) state_nxt = SEND_HI;
         end
         SEND_HI: begin
            bus.out_valid_ee = 1'b1;
            bus.out_nib_ee   = hold[BYTE_W-1:NIB_W];
`ifdef SPLIT_NIBBLE_TX_PARITY_EN
            if (bus.out_ready_ee) state_nxt = SEND_PAR;
`else
            bus.out_last_ee  = 1'b1;
            word_done        = bus.out_ready_ee;
`endif
         end
`ifdef SPLIT_NIBBLE_TX_PARITY_EN
         SEND_PAR: begin
            bus.out_valid_ee = 1'b1;
            bus.out_nib_ee   = {3'b000, ^hold};
            bus.out_last_ee  = 1'b1;
            word_done        = bus.out_ready_ee;
         end
`endif
         default: state_nxt = IDLE;
      endcase
      // Chain straight into the next queued word so there is no idle beat between words.
      if (word_done) begin
         if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            state_nxt = SEND_LO;
         end else begin
            state_nxt = IDLE;
         end
      end
   end

   always_ff @(posedge clk_ee or negedge rst_n_ee) begin
      if (!rst_n_ee) begin
         state       <= IDLE;
         hold        <= '0;
         word_cnt_ee <= '0;
      end else begin
         state <= state_nxt;
         if (fifo_pop)  hold        <= fifo_dout;
         if (word_done) word_cnt_ee <= word_cnt_ee + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_split_nibble_tx.sv
// tb/tb_split_nibble_tx.sv - directed scoreboard bench for split_nibble_tx.
// Honours SPLIT_NIBBLE_TX_PARITY_EN for the expected beat pattern.
module tb_split_nibble_tx;
   import split_tx_pkg::*;

`ifdef SPLIT_NIBBLE_TX_PARITY_EN
   localparam int BEATS = 3;
`else
   localparam int BEATS = 2;
`endif

   logic       clk_ee = 1'b0;
   logic       rst_n_ee;
   logic [7:0] word_cnt_ee;
   logic       busy_ee;
   logic [1:0] word_cnt2;
   logic       busy2;

   int         tests     = 0;
   int         fails     = 0;
   int         exp_words = 0;
   logic [4:0] exp_q[$];

   split_nibble_tx_if bus();
   split_nibble_tx_if bus2();

   assign bus2.in_valid_ee  = bus.in_valid_ee;
   assign bus2.in_data_ee   = bus.in_data_ee;
   assign bus2.out_ready_ee = bus.out_ready_ee;

   always #5 clk_ee = ~clk_ee;

   split_nibble_tx #(.DEPTH(4), .CNT_W(8)) dut (
      .clk_ee      (clk_ee),
      .rst_n_ee    (rst_n_ee),
      .bus         (bus),
      .word_cnt_ee (word_cnt_ee),
      .busy_ee     (busy_ee)
   );

   split_nibble_tx #(.DEPTH(4), .CNT_W(2)) dut2 (
      .clk_ee      (clk_ee),
      .rst_n_ee    (rst_n_ee),
      .bus         (bus2),
      .word_cnt_ee (word_cnt2),
      .busy_ee     (busy2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] b);
      exp_q.push_back({1'b0, b[3:0]});
`ifdef SPLIT_NIBBLE_TX_PARITY_EN
      exp_q.push_back({1'b0, b[7:4]});
      exp_q.push_back({1'b1, 3'b000, ^b});
`else
      exp_q.push_back({1'b1, b[7:4]});
`endif
   endtask

   // Called just after a falling edge with inputs settled; advances one full clock.
   task automatic cycle();
      logic [4:0] e;
      logic       done;
      done = 1'b0;
      if (bus.in_valid_ee && bus.in_ready_ee) push_exp(bus.in_data_ee);
      if (bus.out_valid_ee) begin
         if (exp_q.size() == 0) begin
            check("beat_expected", bus.out_valid_ee, 0);
         end else begin
            e = exp_q[0];
            check("out_nib", bus.out_nib_ee, e[3:0]);
            check("out_last", bus.out_last_ee, e[4]);
            if (bus.out_ready_ee) begin
               void'(exp_q.pop_front());
               if (e[4]) begin
                  exp_words++;
                  done = 1'b1;
               end
            end
         end
      end
      @(posedge clk_ee);
      @(negedge clk_ee);
      if (done) begin
         check("word_cnt", word_cnt_ee, exp_words[7:0]);
         check("word_cnt_w2", word_cnt2, exp_words[1:0]);
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         cycle();
         n++;
      end
      check("drain_done", exp_q.size(), 0);
   endtask

   initial begin
      bus.in_valid_ee  = 1'b0;
      bus.in_data_ee   = 8'h00;
      bus.out_ready_ee = 1'b1;
      rst_n_ee         = 1'b0;
      repeat (2) @(negedge clk_ee);

      check("rst_out_valid", bus.out_valid_ee, 0);
      check("rst_out_nib", bus.out_nib_ee, 0);
      check("rst_out_last", bus.out_last_ee, 0);
      check("rst_word_cnt", word_cnt_ee, 0);
      check("rst_busy", busy_ee, 0);
      check("rst_busy_w2", busy2, 0);
      check("rst_in_ready", bus.in_ready_ee, 1);
      rst_n_ee = 1'b1;
      @(negedge clk_ee);

      // Single word plus first-beat latency
      bus.in_valid_ee = 1'b1;
      bus.in_data_ee  = 8'hA5;
      cycle();
      bus.in_valid_ee = 1'b0;
      check("lat_edge_n1", bus.out_valid_ee, 0);
      check("busy_after_push", busy_ee, 1);
      cycle();
      check("lat_edge_n2", bus.out_valid_ee, 1);
      drain(20);
      check("a5_cnt", word_cnt_ee, 1);
      check("a5_idle_busy", busy_ee, 0);

      // Back-to-back words without a bubble
      bus.in_valid_ee = 1'b1;
      bus.in_data_ee  = 8'h12;
      cycle();
      bus.in_data_ee  = 8'h34;
      cycle();
      bus.in_valid_ee = 1'b0;
      for (int i = 0; i < 2 * BEATS; i++) begin
         check("b2b_valid", bus.out_valid_ee, 1);
         cycle();
      end
      check("b2b_cnt", word_cnt_ee, 3);
      check("b2b_idle", bus.out_valid_ee, 0);

      // Fill FIFO with downstream stalled, then release
      bus.out_ready_ee = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.in_valid_ee = 1'b1;
         bus.in_data_ee  = 8'(i * 37 + 8'h5C);
         check("fill_in_ready", bus.in_ready_ee, 1);
         cycle();
      end
      bus.in_valid_ee = 1'b0;
      check("full_in_ready", bus.in_ready_ee, 0);
      bus.in_valid_ee = 1'b1;
      bus.in_data_ee  = 8'hEE;
      cycle();
      cycle();
      bus.in_valid_ee = 1'b0;
      check("full_in_ready_hold", bus.in_ready_ee, 0);
      bus.out_ready_ee = 1'b1;
      drain(5 * BEATS + 10);
      check("full_cnt", word_cnt_ee, 8);
      check("full_busy", busy_ee, 0);

      // Stall on the low beat of 8'hC3
      bus.out_ready_ee = 1'b0;
      bus.in_valid_ee  = 1'b1;
      bus.in_data_ee   = 8'hC3;
      cycle();
      bus.in_valid_ee  = 1'b0;
      cycle();
      repeat (3) begin
         check("stall_valid", bus.out_valid_ee, 1);
         check("stall_nib", bus.out_nib_ee, 4'h3);
         check("stall_last", bus.out_last_ee, 0);
         cycle();
      end
      bus.out_ready_ee = 1'b1;
      drain(20);
      check("stall_cnt", word_cnt_ee, 9);

      // Reset during the high beat with another byte still queued
      bus.in_valid_ee = 1'b1;
      bus.in_data_ee  = 8'h6B;
      cycle();
      bus.in_data_ee  = 8'h99;
      cycle();
      bus.in_valid_ee = 1'b0;
      cycle();
      check("pre_rst_hi_nib", bus.out_nib_ee, 4'h6);
      rst_n_ee = 1'b0;
      #1;
      check("mid_rst_valid", bus.out_valid_ee, 0);
      check("mid_rst_nib", bus.out_nib_ee, 0);
      check("mid_rst_last", bus.out_last_ee, 0);
      check("mid_rst_cnt", word_cnt_ee, 0);
      check("mid_rst_cnt_w2", word_cnt2, 0);
      check("mid_rst_busy", busy_ee, 0);
      check("mid_rst_in_ready", bus.in_ready_ee, 1);
      exp_q.delete();
      exp_words = 0;
      @(negedge clk_ee);
      rst_n_ee = 1'b1;
      cycle();
      cycle();
      check("post_rst_valid", bus.out_valid_ee, 0);
      check("post_rst_busy", busy_ee, 0);

      bus.in_valid_ee = 1'b1;
      bus.in_data_ee  = 8'h07;
      cycle();
      bus.in_valid_ee = 1'b0;
      cycle();
      check("post_rst_first_nib", bus.out_nib_ee, 4'h7);
      drain(20);
      check("post_rst_cnt", word_cnt_ee, 1);
      check("post_rst_cnt_w2", word_cnt2, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
